// File: rtl/host_cmd_parser.sv
// host_cmd_parser: decodes the host byte protocol arriving from the UART.
// 0x2p + four data bytes writes I/O port p. 0x3p reads port p and returns
// four bytes, MSB first, through the UART transmitter.
module host_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rxready,
    input  logic [7:0]  rxdata,
    input  logic        txready,
    output logic        txen,
    output logic [7:0]  txdata,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  rd_addr,
    output logic        rd_strobe,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic        cmd_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WCOMMIT,
        RLATCH,
        TXSEND,
        TXHOLD,
        TXWAIT
    } state_t;

    state_t          state;
    logic [3:0]      cmd_addr;
    logic [1:0]      byte_cnt;
    logic [23:0]     data_shift;
    logic [TW-1:0]   timer;
    logic [31:0]     tx_shift;
    logic [2:0]      tx_cnt;
    logic            hold_cnt;
    logic            in_read;

    // Any state but IDLE means a command or a response is still in progress.
    assign busy = (state != IDLE);

    // txen is gated with the live txready so a byte can never be handed to a
    // transmitter that is not idle; txdata is already stable in TXSEND.
    assign txen = (state == TXSEND) && txready;

    // The response is running whenever the FSM is in one of the read states.
    assign in_read = (state == RLATCH) || (state == TXSEND) ||
                     (state == TXHOLD) || (state == TXWAIT);

    // Command FSM: byte decoding, write assembly, timeout and read serialisation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cmd_addr   <= '0;
            byte_cnt   <= '0;
            data_shift <= '0;
            timer      <= '0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            hold_cnt   <= 1'b0;
            txdata     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_addr    <= '0;
            rd_strobe  <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_strobe <= 1'b0;
            cmd_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxready) begin
                        if (rxdata[7:4] == 4'h2) begin
                            cmd_addr <= rxdata[3:0];
                            byte_cnt <= '0;
                            timer    <= '0;
                            state    <= WDATA;
                        end else if (rxdata[7:4] == 4'h3) begin
                            rd_addr   <= rxdata[3:0];
                            rd_strobe <= 1'b1;
                            state     <= RLATCH;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (rxready) begin
                        data_shift <= {data_shift[15:0], rxdata};
                        byte_cnt   <= byte_cnt + 2'd1;
                        timer      <= '0;
                        if (byte_cnt == 2'd3) begin
                            wr_addr <= cmd_addr;
                            wr_data <= {data_shift, rxdata};
                            wr_en   <= 1'b1;
                            state   <= WCOMMIT;
                        end
                    end else if (timer == TIMER_LAST) begin
                        cmd_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WCOMMIT: begin
                    state <= IDLE;
                end

                RLATCH: begin
                    txdata   <= rd_data[31:24];
                    tx_shift <= {rd_data[23:0], 8'h00};
                    tx_cnt   <= '0;
                    state    <= TXSEND;
                end

                TXSEND: begin
                    if (txready) begin
                        tx_cnt   <= tx_cnt + 3'd1;
                        hold_cnt <= 1'b0;
                        state    <= TXHOLD;
                    end
                end

                TXHOLD: begin
                    if (hold_cnt) begin
                        state <= TXWAIT;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end

                TXWAIT: begin
                    if (txready) begin
                        if (tx_cnt == 3'd4) begin
                            state <= IDLE;
                        end else begin
                            txdata   <= tx_shift[31:24];
                            tx_shift <= {tx_shift[23:0], 8'h00};
                            state    <= TXSEND;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (rxready && in_read) begin
                cmd_error <= 1'b1;
            end
        end
    end

endmodule
